// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: register-file addressing, EX/MEM operand forwarding,
// load-use hazard detection with bubble insertion, and a saturating bubble counter.
module id_ex_operand_stage #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned OP_SIZE   = 4,
  parameter int unsigned CNT_SIZE  = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ID_VALID,
  input  logic [OP_SIZE-1:0]   ID_OP,
  input  logic [ADDR_SIZE-1:0] ID_RS,
  input  logic [ADDR_SIZE-1:0] ID_RT,
  input  logic                 ID_USE_RS,
  input  logic                 ID_USE_RT,
  input  logic [ADDR_SIZE-1:0] ID_RD,
  input  logic                 ID_WE,
  input  logic                 ID_MEMRD,
  input  logic [WORD_SIZE-1:0] ID_IMM,
  output logic [ADDR_SIZE-1:0] RADDR1,
  output logic [ADDR_SIZE-1:0] RADDR2,
  input  logic [WORD_SIZE-1:0] RDATA1,
  input  logic [WORD_SIZE-1:0] RDATA2,
  input  logic [WORD_SIZE-1:0] EX_ALU_RES,
  input  logic                 MEM_VALID,
  input  logic                 MEM_WE,
  input  logic [ADDR_SIZE-1:0] MEM_WADDR,
  input  logic [WORD_SIZE-1:0] MEM_DATA,
  input  logic                 FLUSH,
  output logic                 STALL_OUT,
  output logic                 EX_VALID,
  output logic [OP_SIZE-1:0]   EX_OP,
  output logic [ADDR_SIZE-1:0] EX_RD,
  output logic                 EX_WE,
  output logic                 EX_MEMRD,
  output logic [WORD_SIZE-1:0] EX_IMM,
  output logic [WORD_SIZE-1:0] EX_A,
  output logic [WORD_SIZE-1:0] EX_B,
  output logic [CNT_SIZE-1:0]  STALL_CNT
);

  logic                 ex_valid_q, ex_valid_d;
  logic [OP_SIZE-1:0]   ex_op_q, ex_op_d;
  logic [ADDR_SIZE-1:0] ex_rd_q, ex_rd_d;
  logic                 ex_we_q, ex_we_d;
  logic                 ex_memrd_q, ex_memrd_d;
  logic [WORD_SIZE-1:0] ex_imm_q, ex_imm_d;
  logic [WORD_SIZE-1:0] ex_a_q, ex_a_d;
  logic [WORD_SIZE-1:0] ex_b_q, ex_b_d;
  logic [CNT_SIZE-1:0]  stall_cnt_q, stall_cnt_d;

  logic                 hazard;
  logic                 ex_fwd_ok, mem_fwd_ok;
  logic [WORD_SIZE-1:0] fwd_a, fwd_b;

  assign RADDR1 = ID_RS;
  assign RADDR2 = ID_RT;

  // Load-use hazard: a load in EX cannot supply its data until it reaches MEM.
  always_comb begin
    hazard    = ID_VALID & ex_valid_q & ex_memrd_q & ex_we_q &
                ((ID_USE_RS & (ID_RS == ex_rd_q)) | (ID_USE_RT & (ID_RT == ex_rd_q)));
    STALL_OUT = hazard & ~FLUSH;
  end

  // Operand forwarding: youngest producer (EX non-load) wins over MEM, then register file.
  always_comb begin
    ex_fwd_ok  = ex_valid_q & ex_we_q & ~ex_memrd_q;
    mem_fwd_ok = MEM_VALID & MEM_WE;
    fwd_a      = RDATA1;
    fwd_b      = RDATA2;
    if (ex_fwd_ok && (ex_rd_q == ID_RS)) begin
      fwd_a = EX_ALU_RES;
    end else if (mem_fwd_ok && (MEM_WADDR == ID_RS)) begin
      fwd_a = MEM_DATA;
    end
    if (ex_fwd_ok && (ex_rd_q == ID_RT)) begin
      fwd_b = EX_ALU_RES;
    end else if (mem_fwd_ok && (MEM_WADDR == ID_RT)) begin
      fwd_b = MEM_DATA;
    end
  end

  // Next-state for the EX bundle: flush kills, hazard inserts a bubble, otherwise advance.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_op_d     = ex_op_q;
    ex_rd_d     = ex_rd_q;
    ex_we_d     = ex_we_q;
    ex_memrd_d  = ex_memrd_q;
    ex_imm_d    = ex_imm_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    stall_cnt_d = stall_cnt_q;
    if (FLUSH) begin
      ex_valid_d = 1'b0;
      ex_we_d    = 1'b0;
      ex_memrd_d = 1'b0;
    end else if (hazard) begin
      ex_valid_d = 1'b0;
      ex_we_d    = 1'b0;
      ex_memrd_d = 1'b0;
      if (stall_cnt_q != {CNT_SIZE{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_SIZE'(1);
      end
    end else begin
      ex_valid_d = ID_VALID;
      ex_we_d    = ID_WE & ID_VALID;
      ex_memrd_d = ID_MEMRD & ID_VALID;
      ex_op_d    = ID_OP;
      ex_rd_d    = ID_RD;
      ex_imm_d   = ID_IMM;
      ex_a_d     = fwd_a;
      ex_b_d     = fwd_b;
    end
  end

  // EX bundle and bubble counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_rd_q     <= '0;
      ex_we_q     <= 1'b0;
      ex_memrd_q  <= 1'b0;
      ex_imm_q    <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_memrd_q  <= ex_memrd_d;
      ex_imm_q    <= ex_imm_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign EX_VALID  = ex_valid_q;
  assign EX_OP     = ex_op_q;
  assign EX_RD     = ex_rd_q;
  assign EX_WE     = ex_we_q;
  assign EX_MEMRD  = ex_memrd_q;
  assign EX_IMM    = ex_imm_q;
  assign EX_A      = ex_a_q;
  assign EX_B      = ex_b_q;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: stimulus pushes hand-computed expectations,
// a monitor pops and compares them when the DUT outputs are sampled.
module tb_id_ex_operand_stage;

  logic        CLK, RST_N;
  logic        ID_VALID, ID_USE_RS, ID_USE_RT, ID_WE, ID_MEMRD;
  logic [3:0]  ID_OP, ID_RS, ID_RT, ID_RD;
  logic [15:0] ID_IMM;
  logic [3:0]  RADDR1, RADDR2;
  logic [15:0] RDATA1, RDATA2, EX_ALU_RES;
  logic        MEM_VALID, MEM_WE;
  logic [3:0]  MEM_WADDR;
  logic [15:0] MEM_DATA;
  logic        FLUSH, STALL_OUT;
  logic        EX_VALID, EX_WE, EX_MEMRD;
  logic [3:0]  EX_OP, EX_RD;
  logic [15:0] EX_IMM, EX_A, EX_B, STALL_CNT;

  id_ex_operand_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .ID_VALID(ID_VALID), .ID_OP(ID_OP), .ID_RS(ID_RS), .ID_RT(ID_RT),
    .ID_USE_RS(ID_USE_RS), .ID_USE_RT(ID_USE_RT), .ID_RD(ID_RD), .ID_WE(ID_WE),
    .ID_MEMRD(ID_MEMRD), .ID_IMM(ID_IMM),
    .RADDR1(RADDR1), .RADDR2(RADDR2), .RDATA1(RDATA1), .RDATA2(RDATA2),
    .EX_ALU_RES(EX_ALU_RES),
    .MEM_VALID(MEM_VALID), .MEM_WE(MEM_WE), .MEM_WADDR(MEM_WADDR), .MEM_DATA(MEM_DATA),
    .FLUSH(FLUSH), .STALL_OUT(STALL_OUT),
    .EX_VALID(EX_VALID), .EX_OP(EX_OP), .EX_RD(EX_RD), .EX_WE(EX_WE),
    .EX_MEMRD(EX_MEMRD), .EX_IMM(EX_IMM), .EX_A(EX_A), .EX_B(EX_B),
    .STALL_CNT(STALL_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic        st, v, we, mr, chk;
    logic [3:0]  op, rd;
    logic [15:0] imm, a, b, cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  event async_ev;

  task automatic cmp(input string nm, input string f, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
    end
  endtask

  task automatic push_exp(input string nm, input logic st, input logic v, input logic we,
                          input logic mr, input logic chk, input logic [3:0] op,
                          input logic [3:0] rd, input logic [15:0] imm, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] cnt);
    exp_t e;
    e.nm = nm; e.st = st; e.v = v; e.we = we; e.mr = mr; e.chk = chk;
    e.op = op; e.rd = rd; e.imm = imm; e.a = a; e.b = b; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic id_set(input logic v, input logic [3:0] op, input logic [3:0] rs,
                        input logic [3:0] rt, input logic urs, input logic urt,
                        input logic [3:0] rd, input logic we, input logic mr,
                        input logic [15:0] imm);
    ID_VALID = v; ID_OP = op; ID_RS = rs; ID_RT = rt; ID_USE_RS = urs; ID_USE_RT = urt;
    ID_RD = rd; ID_WE = we; ID_MEMRD = mr; ID_IMM = imm;
  endtask

  task automatic mem_set(input logic v, input logic we, input logic [3:0] wa,
                         input logic [15:0] d);
    MEM_VALID = v; MEM_WE = we; MEM_WADDR = wa; MEM_DATA = d;
  endtask

  task automatic rf_set(input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] alu);
    RDATA1 = d1; RDATA2 = d2; EX_ALU_RES = alu;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares on every falling edge, or immediately on an asynchronous check.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK or async_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.nm, "STALL_OUT", {15'd0, STALL_OUT}, {15'd0, e.st});
        cmp(e.nm, "EX_VALID", {15'd0, EX_VALID}, {15'd0, e.v});
        cmp(e.nm, "EX_WE", {15'd0, EX_WE}, {15'd0, e.we});
        cmp(e.nm, "EX_MEMRD", {15'd0, EX_MEMRD}, {15'd0, e.mr});
        cmp(e.nm, "STALL_CNT", STALL_CNT, e.cnt);
        if (e.chk) begin
          cmp(e.nm, "EX_OP", {12'd0, EX_OP}, {12'd0, e.op});
          cmp(e.nm, "EX_RD", {12'd0, EX_RD}, {12'd0, e.rd});
          cmp(e.nm, "EX_IMM", EX_IMM, e.imm);
          cmp(e.nm, "EX_A", EX_A, e.a);
          cmp(e.nm, "EX_B", EX_B, e.b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b1;
    FLUSH = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    mem_set(0, 0, 0, 16'h0);
    rf_set(16'h0, 16'h0, 16'h0);
    #1 RST_N = 1'b0;
    next_cycle();
    next_cycle();
    push_exp("reset", 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);

    // A: plain register-file operands, writes r3.
    next_cycle();
    RST_N = 1'b1;
    id_set(1, 4'h1, 4'd1, 4'd2, 1, 1, 4'd3, 1, 0, 16'h0005);
    rf_set(16'h2222, 16'h4444, 16'h0000);
    push_exp("pre_a", 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);

    // B: r3 produced by both EX and MEM; EX wins.
    next_cycle();
    id_set(1, 4'h2, 4'd3, 4'd2, 1, 1, 4'd6, 1, 0, 16'h0007);
    rf_set(16'h1111, 16'h3333, 16'h00AA);
    mem_set(1, 1, 4'd3, 16'h00BB);
    push_exp("plain", 0, 1, 1, 0, 1, 4'h1, 4'd3, 16'h0005, 16'h2222, 16'h4444, 16'h0);

    // C: EX writer of r3 retired, MEM supplies r3; RT=6 from EX.
    next_cycle();
    id_set(1, 4'h3, 4'd3, 4'd6, 1, 1, 4'd7, 1, 0, 16'h0008);
    rf_set(16'h1111, 16'h3333, 16'h0CCC);
    push_exp("ex_fwd", 0, 1, 1, 0, 1, 4'h2, 4'd6, 16'h0007, 16'h00AA, 16'h3333, 16'h0);

    // D: load writing r5.
    next_cycle();
    id_set(1, 4'h4, 4'd1, 4'd0, 1, 0, 4'd5, 1, 1, 16'h0010);
    rf_set(16'h0100, 16'h9999, 16'h0500);
    mem_set(0, 0, 4'd0, 16'h0);
    push_exp("mem_fwd", 0, 1, 1, 0, 1, 4'h3, 4'd7, 16'h0008, 16'h00BB, 16'h0CCC, 16'h0);

    // E: consumer of r5 via RT: load-use stall.
    next_cycle();
    id_set(1, 4'h5, 4'd2, 4'd5, 1, 1, 4'd8, 1, 0, 16'h0020);
    rf_set(16'h0202, 16'h5555, 16'h0110);
    push_exp("load_use", 1, 1, 1, 1, 1, 4'h4, 4'd5, 16'h0010, 16'h0100, 16'h9999, 16'h0);

    // F: bubble in EX (never forwards); load now in MEM.
    next_cycle();
    rf_set(16'h0202, 16'h5555, 16'hDEAD);
    mem_set(1, 1, 4'd5, 16'h1234);
    push_exp("bubble", 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h1);

    // G: load writing r9.
    next_cycle();
    id_set(1, 4'h4, 4'd0, 4'd0, 1, 0, 4'd9, 1, 1, 16'h0030);
    rf_set(16'h0001, 16'h0000, 16'h0000);
    mem_set(0, 0, 4'd0, 16'h0);
    push_exp("after_stall", 0, 1, 1, 0, 1, 4'h5, 4'd8, 16'h0020, 16'h0202, 16'h1234, 16'h1);

    // H: consumer of r9 with FLUSH: no stall, killed.
    next_cycle();
    id_set(1, 4'h6, 4'd9, 4'd0, 1, 0, 4'd10, 1, 0, 16'h0040);
    FLUSH = 1'b1;
    push_exp("load_b", 0, 1, 1, 1, 1, 4'h4, 4'd9, 16'h0030, 16'h0001, 16'h0000, 16'h1);

    // I: load writing r11.
    next_cycle();
    FLUSH = 1'b0;
    id_set(1, 4'h4, 4'd0, 4'd0, 1, 0, 4'd11, 1, 1, 16'h0050);
    rf_set(16'h0002, 16'h0000, 16'h0000);
    push_exp("flushed", 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h1);

    // J: consumer of r11 stalls with the counter preloaded to all-ones.
    next_cycle();
    id_set(1, 4'h7, 4'd11, 4'd0, 1, 0, 4'd12, 1, 0, 16'h0060);
    rf_set(16'h7777, 16'h0000, 16'h0000);
    push_exp("load_c", 1, 1, 1, 1, 1, 4'h4, 4'd11, 16'h0050, 16'h0002, 16'h0000, 16'h1);
    @(negedge CLK);
    #1;
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;

    // K: held consumer, load in MEM; counter must not wrap.
    next_cycle();
    mem_set(1, 1, 4'd11, 16'hABCD);
    push_exp("saturate", 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'hFFFF);

    // L: first of two back-to-back loads (r13).
    next_cycle();
    id_set(1, 4'h4, 4'd0, 4'd0, 1, 0, 4'd13, 1, 1, 16'h0000);
    rf_set(16'h0000, 16'h0000, 16'h0000);
    mem_set(0, 0, 4'd0, 16'h0);
    push_exp("sat_release", 0, 1, 1, 0, 1, 4'h7, 4'd12, 16'h0060, 16'hABCD, 16'h0000,
             16'hFFFF);

    // M: second load (r14).
    next_cycle();
    id_set(1, 4'h4, 4'd0, 4'd0, 1, 0, 4'd14, 1, 1, 16'h0000);
    rf_set(16'h0003, 16'h0000, 16'h0000);
    push_exp("load_13", 0, 1, 1, 1, 1, 4'h4, 4'd13, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);

    // N: consumer of r13 (in MEM) and r14 (in EX): only r14 stalls.
    next_cycle();
    id_set(1, 4'h8, 4'd13, 4'd14, 1, 1, 4'd15, 1, 0, 16'h0070);
    mem_set(1, 1, 4'd13, 16'h1313);
    rf_set(16'h0000, 16'h0000, 16'h0000);
    push_exp("two_loads", 1, 1, 1, 1, 1, 4'h4, 4'd14, 16'h0000, 16'h0003, 16'h0000, 16'hFFFF);

    // Reset mid-stall between clock edges.
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    push_exp("async_rst", 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    ->async_ev;

    next_cycle();
    RST_N = 1'b1;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    mem_set(0, 0, 4'd0, 16'h0);
    push_exp("post_rst", 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage of the 16-bit pipelined CPU, sitting directly downstream of the register file.
- Drives the register-file read addresses and captures the read operands. Applies EX→ID and MEM→ID operand forwarding, detects load-use hazards, and inserts bubbles.
- Presents a registered operand bundle to the EX stage and counts inserted stall bubbles.
- Write-back-stage results need no forwarding: the register file writes on negedge CLK and reads combinationally, so the written value is visible before the capturing posedge.

Parameters:
WORD_SIZE, 16, operand/data width
ADDR_SIZE, 4, register address width (16 registers; r0 is an ordinary writable register)
OP_SIZE, 4, opcode width passed through to EX
CNT_SIZE, 16, width of the stall-bubble counter

Ports:
CLK  input  1  clock; all state updates on posedge
RST_N  input  1  asynchronous active-low reset
ID_VALID  input  1  decode holds a valid instruction
ID_OP  input  OP_SIZE  opcode
ID_RS  input  ADDR_SIZE  source register 1
ID_RT  input  ADDR_SIZE  source register 2
ID_USE_RS  input  1  instruction reads RS
ID_USE_RT  input  1  instruction reads RT
ID_RD  input  ADDR_SIZE  destination register
ID_WE  input  1  instruction writes RD
ID_MEMRD  input  1  instruction is a load
ID_IMM  input  WORD_SIZE  sign-extended immediate
RADDR1  output  ADDR_SIZE  register-file read address 1 (= ID_RS, combinational)
RADDR2  output  ADDR_SIZE  register-file read address 2 (= ID_RT, combinational)
RDATA1  input  WORD_SIZE  register-file read data 1
RDATA2  input  WORD_SIZE  register-file read data 2
EX_ALU_RES  input  WORD_SIZE  combinational ALU result of the instruction currently in EX
MEM_VALID  input  1  MEM stage holds a valid instruction
MEM_WE  input  1  MEM instruction writes a register
MEM_WADDR  input  ADDR_SIZE  MEM destination register
MEM_DATA  input  WORD_SIZE  MEM final result (load data or ALU result)
FLUSH  input  1  branch taken; kill the instruction in ID
STALL_OUT  output  1  hold fetch/decode this cycle (combinational)
EX_VALID, EX_OP, EX_RD, EX_WE, EX_MEMRD, EX_IMM  output  1/OP/ADDR/1/1/WORD  registered pass-through to EX
EX_A  output  WORD_SIZE  registered operand A
EX_B  output  WORD_SIZE  registered operand B
STALL_CNT  output  CNT_SIZE  saturating count of load-use bubbles

Behaviour:
- Reset (RST_N low, asynchronous): all EX_* outputs are 0 and STALL_CNT is 0. STALL_OUT is 0 while in reset because EX_VALID is 0.
- Hazard (combinational):
  - Condition: ID_VALID & EX_VALID & EX_MEMRD & EX_WE & ((ID_USE_RS & ID_RS==EX_RD) | (ID_USE_RT & ID_RT==EX_RD)).
  - STALL_OUT = hazard & ~FLUSH.
- Operand A selection, in priority order (operand B is identical using ID_RT and RDATA2):
  1. EX_VALID & EX_WE & ~EX_MEMRD & EX_RD==ID_RS → EX_ALU_RES.
  2. Else MEM_VALID & MEM_WE & MEM_WADDR==ID_RS → MEM_DATA.
  3. Else RDATA1.
  - Forwarding ignores ID_USE_*; the value is harmless if the operand is unused.
- Each posedge, first matching case applies:
  - FLUSH=1: EX_VALID←0, EX_WE←0, EX_MEMRD←0; other EX_* fields are don't-care (hold). STALL_CNT unchanged.
  - hazard=1: bubble inserted: EX_VALID←0, EX_WE←0, EX_MEMRD←0. STALL_CNT←STALL_CNT+1, saturating at all-ones. ID contents are held upstream via STALL_OUT.
  - otherwise: EX_VALID←ID_VALID. EX_WE←ID_WE&ID_VALID. EX_MEMRD←ID_MEMRD&ID_VALID. EX_OP, EX_RD and EX_IMM are captured. EX_A and EX_B take the forwarded values.
- Latency: one cycle ID→EX. A load-use pair costs exactly one bubble. On the following cycle the load is in MEM and its data is forwarded via MEM_DATA.
- A bubble never forwards and never causes a hazard, because EX_VALID=0 and EX_WE=0.
- Two consecutive loads feeding a consumer: only the load in EX stalls; a load in MEM forwards normally.
- Reset asserted mid-stall: everything clears immediately; STALL_OUT drops asynchronously.
- No internal memory of held instructions; upstream guarantees ID_* stays stable while STALL_OUT=1.

Test Plan:
- Reset, then ID: RS=1, RT=2, no forwarding, RDATA1=16'h2222, RDATA2=16'h4444, ID_IMM=16'h0005 → after 1 posedge: EX_A=16'h2222, EX_B=16'h4444, EX_IMM=16'h0005, EX_VALID=1, STALL_OUT=0.
- EX holds a non-load writing r3 with EX_ALU_RES=16'h00AA; MEM writes r3 with MEM_DATA=16'h00BB; ID RS=3 → EX_A=16'h00AA. Retire the EX writer → EX_A=16'h00BB.
- Load in EX writing r5; ID uses RT=5 → STALL_OUT=1, next EX_VALID=0, STALL_CNT=1. Next cycle the load is in MEM with MEM_DATA=16'h1234 → EX_B=16'h1234, EX_VALID=1.
- Same hazard with FLUSH=1 → STALL_OUT=0, EX_VALID=0 next cycle, STALL_CNT unchanged.
- Preload STALL_CNT to 16'hFFFF via repeated hazards (or force) → a further hazard keeps 16'hFFFF.
- Drive RST_N low between clock edges during a stall → EX_* and STALL_CNT are 0 and STALL_OUT is 0 immediately, without a clock edge.
